instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch sequencer on the write side of the instruction register. Owns the program counter, addresses the synchronous program memory, and drives `I_fetch`/`en_IR` so that the instruction register loads exactly once per instruction. Steps the processor through its four operating cycles (address, load, execute, writeback), with branch redirect and halt/start control. Sits between the program memory and the instruction register; the control unit consumes `phase`.

## Interface
- `PC_W`, default 8: program counter and address width.
- `INSTR_W`, default 16: instruction width.
- `RESET_PC`, default 0: PC value loaded at reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: leave IDLE/HALTED and begin fetching.
- `halt_req` in 1: stop after the current instruction; sampled in WB.
- `branch_en` in 1: redirect the PC; sampled in WB.
- `branch_addr` in PC_W: redirect target.
- `pm_addr` out PC_W: program memory address; equals `pc` combinationally.
- `pm_data` in INSTR_W: program memory read data, valid one cycle after the address.
- `I_fetch` out INSTR_W: instruction to the IR; combinational copy of `pm_data`.
- `en_IR` out 1: IR load enable.
- `phase` out 2: 0=ADDR, 1=LOAD, 2=EXEC, 3=WB; held at 0 when not running.
- `pc` out PC_W: current program counter.
- `running` out 1: high in ADDR/LOAD/EXEC/WB.
- `halted` out 1: high in HALTED.
- `retired` out 16: count of completed instructions, saturating.

## Operation
States: IDLE, ADDR, LOAD, EXEC, WB, HALTED.

Reset values: state=IDLE, `pc`=RESET_PC, `en_IR`=0, `phase`=0, `running`=0, `halted`=0, `retired`=0.

Transitions:
- IDLE, start=1 → ADDR. Otherwise stay.
- ADDR → LOAD unconditionally. `pm_addr`=`pc` is presented.
- LOAD → EXEC.
  - `en_IR`=1 only in this state, so the IR captures `pm_data` at the end of LOAD.
  - `pc` ← `pc`+1 at that same edge, wrapping 2^PC_W−1 → 0.
- EXEC → WB. No PC action.
- WB, with `branch_en`=1: `pc` ← `branch_addr`, overriding the earlier increment.
- WB exit: `retired` increments, saturating at 0xFFFF. Next state is HALTED if `halt_req`=1, else ADDR.
- WB, with `branch_en` and `halt_req` both high: the branch is applied first, then HALTED. On restart, fetch resumes at `branch_addr`.
- HALTED, start=1 → ADDR. `pc` is unchanged.

Other rules:
- `start` is ignored while running.
- `halt_req` and `branch_en` are ignored outside WB.
- `halt_req` does not need to be held; only its WB-cycle value matters.
- Reset asserted mid-instruction forces the reset values immediately and asynchronously. `en_IR` drops the same instant, so no partial load can occur.

## Timing
- Steady-state throughput is one instruction per 4 cycles.
- `en_IR` is high exactly one cycle in four.
- Start latency:
  - `start` sampled high at edge N puts the FSM in ADDR during cycle N+1.
  - `en_IR` is high in cycle N+2; the IR holds the new instruction from edge N+3.
- Program memory contract: the address is stable throughout ADDR and LOAD; data sampled at the end of LOAD reflects the address from ADDR.
- Branch: a redirect in WB at edge M makes `pm_addr`=`branch_addr` during ADDR in cycle M+1. There is no wasted fetch.
- All outputs are registered except `pm_addr` (=`pc`) and `I_fetch` (=`pm_data`).

## Structure
- Shared package `risc_pkg` holds:
  - phase encodings `PH_ADDR`/`PH_LOAD`/`PH_EXEC`/`PH_WB`;
  - the FSM state enum;
  - `PC_W`/`INSTR_W` defaults.
- One sub-module, `program_counter`:
  - ports: `clk`, `rst`, `inc`, `load`, `load_val`, `pc`;
  - priority: load over inc;
  - async reset to RESET_PC.
- FSM, `retired` counter and output decode live in the top.

## Test plan
- Reset then start=1 for one cycle, memory preloaded with mem[0]=16'hA001 and mem[1]=16'hB002:
  - `en_IR` pulses in cycles 2 and 6;
  - `I_fetch` is A001 then B002 at those pulses;
  - `phase` runs 0,1,2,3 repeating.
- Branch: `branch_en`=1, `branch_addr`=8'h40 in the first WB → next ADDR shows `pm_addr`=8'h40 and `retired`=1.
- Wrap: RESET_PC=8'hFF, start → after LOAD, `pc`=8'h00; the next fetch comes from address 0.
- Halt with branch: `halt_req`=1 and `branch_en`=1 (addr 8'h10) in the same WB → HALTED, `halted`=1, `pc`=8'h10, `en_IR` stays 0. A later start resumes at 8'h10.
- Ignored controls: `halt_req` pulsed in EXEC only → no halt; `start` pulsed while running → no effect on sequence.
- Async reset: assert `rst` mid-LOAD with `en_IR`=1 → `en_IR`=0, `pc`=RESET_PC and state IDLE before the next clock edge; `retired`=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the fetch sequencer: phase codes, FSM states, width defaults.
// Latency: n/a (package).
// Backpressure: n/a (package).
package risc_pkg;

  localparam int DEFAULT_PC_W    = 8;
  localparam int DEFAULT_INSTR_W = 16;
  localparam int RETIRED_W       = 16;

  // Phase codes seen by the control unit
  localparam logic [1:0] PH_ADDR = 2'd0;
  localparam logic [1:0] PH_LOAD = 2'd1;
  localparam logic [1:0] PH_EXEC = 2'd2;
  localparam logic [1:0] PH_WB   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LOAD,
    ST_EXEC,
    ST_WB,
    ST_HALTED
  } fetch_state_t;

  // Retired-instruction counter step: sticks at all-ones instead of wrapping
  function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] v);
    return (v == {RETIRED_W{1'b1}}) ? v : v + RETIRED_W'(1);
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register with branch load and sequential increment.
// Latency: new value visible one cycle after inc/load is sampled.
// Backpressure: none; inc/load act on every rising edge they are asserted.
//
// Ports: clk, rst (async, active-high), inc (pc+1, wrapping), load (pc=load_val,
//        wins over inc), load_val, pc (current value).
module program_counter #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      // natural modulo-2^PC_W wrap
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: steps ADDR/LOAD/EXEC/WB, owns the PC, loads the IR once per instruction.
// Latency: start at edge N -> ADDR in N+1, en_IR in N+2; one instruction per 4 cycles.
// Backpressure: none; halt_req/branch_en sampled only in WB, start only in IDLE/HALTED.
//
// Ports: clk, rst (async, active-high); start, halt_req, branch_en, branch_addr (control);
//        pm_addr/pm_data (synchronous program memory, 1-cycle read); I_fetch/en_IR (to IR);
//        phase, pc, running, halted, retired (status, all registered except pm_addr/I_fetch).
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter int              INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic                 branch_en,
  input  logic [PC_W-1:0]      branch_addr,
  output logic [PC_W-1:0]      pm_addr,
  input  logic [INSTR_W-1:0]   pm_data,
  output logic [INSTR_W-1:0]   I_fetch,
  output logic                 en_IR,
  output logic [1:0]           phase,
  output logic [PC_W-1:0]      pc,
  output logic                 running,
  output logic                 halted,
  output logic [RETIRED_W-1:0] retired
);

  fetch_state_t state;
  logic         pc_inc;
  logic         pc_load;

  // Increment at the end of LOAD, after the IR has taken the word at the old
  // address; a WB branch then overwrites that increment.
  assign pc_inc  = (state == ST_LOAD);
  assign pc_load = (state == ST_WB) && branch_en;

  program_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (branch_addr),
    .pc       (pc)
  );

  assign pm_addr = pc;
  assign I_fetch = pm_data;

  // Outputs are registered alongside the state: each branch writes the values
  // that belong to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      en_IR   <= 1'b0;
      phase   <= PH_ADDR;
      running <= 1'b0;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state   <= ST_ADDR;
            phase   <= PH_ADDR;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        ST_ADDR: begin
          state <= ST_LOAD;
          phase <= PH_LOAD;
          en_IR <= 1'b1;
        end
        ST_LOAD: begin
          state <= ST_EXEC;
          phase <= PH_EXEC;
          en_IR <= 1'b0;
        end
        ST_EXEC: begin
          state <= ST_WB;
          phase <= PH_WB;
        end
        ST_WB: begin
          retired <= sat_inc(retired);
          phase   <= PH_ADDR;
          if (halt_req) begin
            state   <= ST_HALTED;
            running <= 1'b0;
            halted  <= 1'b1;
          end else begin
            state <= ST_ADDR;
          end
        end
        default: begin
          state   <= ST_IDLE;
          en_IR   <= 1'b0;
          phase   <= PH_ADDR;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, corner sequences, randomized run.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start, halt_req, branch_en;
  logic [7:0]  branch_addr;
  logic [7:0]  pm_addr;
  logic [15:0] pm_data;
  logic [15:0] I_fetch;
  logic        en_IR;
  logic [1:0]  phase;
  logic [7:0]  pc;
  logic        running, halted;
  logic [15:0] retired;

  // second instance for the PC wrap case
  logic        w_start;
  logic [7:0]  w_pm_addr;
  logic [15:0] w_pm_data;
  logic [15:0] w_I_fetch;
  logic        w_en_IR;
  logic [1:0]  w_phase;
  logic [7:0]  w_pc;
  logic        w_running, w_halted;
  logic [15:0] w_retired;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .branch_en(branch_en), .branch_addr(branch_addr),
    .pm_addr(pm_addr), .pm_data(pm_data), .I_fetch(I_fetch), .en_IR(en_IR),
    .phase(phase), .pc(pc), .running(running), .halted(halted), .retired(retired)
  );

  instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'hFF)) u_wrap (
    .clk(clk), .rst(rst), .start(w_start), .halt_req(1'b0),
    .branch_en(1'b0), .branch_addr(8'h00),
    .pm_addr(w_pm_addr), .pm_data(w_pm_data), .I_fetch(w_I_fetch), .en_IR(w_en_IR),
    .phase(w_phase), .pc(w_pc), .running(w_running), .halted(w_halted), .retired(w_retired)
  );

  function automatic logic [15:0] mem_val(input logic [7:0] a);
    if (a == 8'h00) return 16'hA001;
    if (a == 8'h01) return 16'hB002;
    return {a, ~a};
  endfunction

  // synchronous program memory, one-cycle read
  always @(posedge clk) begin
    pm_data   <= mem_val(pm_addr);
    w_pm_data <= mem_val(w_pm_addr);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       st;
    logic       hr;
    logic       br;
    logic [7:0] ba;
    logic [1:0] ph;
    logic       en;
    logic [7:0] addr;
    logic       run;
    logic       hlt;
    logic [15:0] ret;
  } vec_t;

  function automatic vec_t mk(input logic st, hr, br, input logic [7:0] ba,
                              input logic [1:0] ph, input logic en, input logic [7:0] addr,
                              input logic run, hlt, input logic [15:0] ret);
    vec_t v;
    v.st = st; v.hr = hr; v.br = br; v.ba = ba; v.ph = ph; v.en = en;
    v.addr = addr; v.run = run; v.hlt = hlt; v.ret = ret;
    return v;
  endfunction

  task automatic noise(input logic allow_start);
    start       = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
    halt_req    = 1'($urandom_range(0, 1));
    branch_en   = 1'($urandom_range(0, 1));
    branch_addr = 8'($urandom);
  endtask

  initial begin
    vec_t tbl[16];
    logic [7:0]  pc_m;
    logic [15:0] ret_m;
    logic        do_br, do_halt;
    logic [7:0]  tgt;

    // each row: inputs applied, one edge, then the outputs of the new cycle
    tbl[0]  = mk(1,0,0,8'h00, 2'd0,0,8'h00,1,0,16'd0);
    tbl[1]  = mk(1,0,0,8'h00, 2'd1,1,8'h00,1,0,16'd0);   // start ignored while running
    tbl[2]  = mk(0,1,0,8'h00, 2'd2,0,8'h01,1,0,16'd0);   // halt in LOAD ignored
    tbl[3]  = mk(0,1,1,8'h55, 2'd3,0,8'h01,1,0,16'd0);   // halt/branch in EXEC ignored
    tbl[4]  = mk(0,0,0,8'h00, 2'd0,0,8'h01,1,0,16'd1);
    tbl[5]  = mk(1,0,0,8'h00, 2'd1,1,8'h01,1,0,16'd1);
    tbl[6]  = mk(0,0,0,8'h00, 2'd2,0,8'h02,1,0,16'd1);
    tbl[7]  = mk(0,0,0,8'h00, 2'd3,0,8'h02,1,0,16'd1);
    tbl[8]  = mk(0,0,1,8'h40, 2'd0,0,8'h40,1,0,16'd2);   // branch in WB
    tbl[9]  = mk(0,0,0,8'h00, 2'd1,1,8'h40,1,0,16'd2);
    tbl[10] = mk(0,1,0,8'h00, 2'd2,0,8'h41,1,0,16'd2);
    tbl[11] = mk(0,0,0,8'h00, 2'd3,0,8'h41,1,0,16'd2);
    tbl[12] = mk(0,1,1,8'h10, 2'd0,0,8'h10,0,1,16'd3);   // branch + halt in WB
    tbl[13] = mk(0,1,1,8'h77, 2'd0,0,8'h10,0,1,16'd3);   // controls ignored when halted
    tbl[14] = mk(1,0,0,8'h00, 2'd0,0,8'h10,1,0,16'd3);   // restart at branch target
    tbl[15] = mk(0,0,0,8'h00, 2'd1,1,8'h10,1,0,16'd3);

    rst = 1'b1; start = 1'b0; halt_req = 1'b0; branch_en = 1'b0;
    branch_addr = 8'h00; w_start = 1'b0;
    tick(); tick();
    chk("rst_phase",   32'(phase),   32'd0);
    chk("rst_en_IR",   32'(en_IR),   32'd0);
    chk("rst_pc",      32'(pc),      32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_halted",  32'(halted),  32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_w_pc",    32'(w_pc),    32'hFF);
    chk("rst_w_halted",32'(w_halted),32'd0);
    rst = 1'b0;
    halt_req = 1'b1; branch_en = 1'b1; branch_addr = 8'h33;
    tick();
    chk("idle_stays_running", 32'(running), 32'd0);
    chk("idle_stays_pc",      32'(pc),      32'd0);

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st; halt_req = tbl[i].hr;
      branch_en = tbl[i].br; branch_addr = tbl[i].ba;
      tick();
      chk($sformatf("v%0d_phase", i),   32'(phase),   32'(tbl[i].ph));
      chk($sformatf("v%0d_en_IR", i),   32'(en_IR),   32'(tbl[i].en));
      chk($sformatf("v%0d_pm_addr", i), 32'(pm_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_running", i), 32'(running), 32'(tbl[i].run));
      chk($sformatf("v%0d_halted", i),  32'(halted),  32'(tbl[i].hlt));
      chk($sformatf("v%0d_retired", i), 32'(retired), 32'(tbl[i].ret));
      if (tbl[i].en)
        chk($sformatf("v%0d_I_fetch", i), 32'(I_fetch), 32'(mem_val(tbl[i].addr)));
    end
    start = 1'b0; halt_req = 1'b0; branch_en = 1'b0;

    // async reset while in LOAD with en_IR high; check before the next edge
    rst = 1'b1;
    #1;
    chk("arst_en_IR",   32'(en_IR),   32'd0);
    chk("arst_pc",      32'(pc),      32'd0);
    chk("arst_phase",   32'(phase),   32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_halted",  32'(halted),  32'd0);
    chk("arst_retired", 32'(retired), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle", 32'(running), 32'd0);

    // PC wrap from 0xFF
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    chk("wrap_addr0",  32'(w_pm_addr), 32'hFF);
    chk("wrap_run",    32'(w_running), 32'd1);
    tick();
    chk("wrap_en0",    32'(w_en_IR),   32'd1);
    chk("wrap_if0",    32'(w_I_fetch), 32'(mem_val(8'hFF)));
    tick();
    chk("wrap_pc",     32'(w_pc),      32'h00);
    tick(); tick();
    chk("wrap_addr1",  32'(w_pm_addr), 32'h00);
    chk("wrap_ret",    32'(w_retired), 32'd1);
    tick();
    chk("wrap_phase1", 32'(w_phase),   32'd1);
    chk("wrap_if1",    32'(w_I_fetch), 32'hA001);

    // randomized run against an instruction-level model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_m = 8'h00; ret_m = 16'd0;
    noise(1'b0); start = 1'b1;
    tick();
    for (int k = 0; k < 400; k++) begin
      chk("r_addr_phase",  32'(phase),   32'd0);
      chk("r_addr_pm",     32'(pm_addr), 32'(pc_m));
      chk("r_addr_retired",32'(retired), 32'(ret_m));
      noise(1'b1); tick();
      chk("r_load_en",     32'(en_IR),   32'd1);
      chk("r_load_pm",     32'(pm_addr), 32'(pc_m));
      chk("r_load_ifetch", 32'(I_fetch), 32'(mem_val(pc_m)));
      noise(1'b1); tick();
      chk("r_exec_en",     32'(en_IR),   32'd0);
      chk("r_exec_pc",     32'(pc),      32'(8'(pc_m + 8'd1)));
      noise(1'b1); tick();
      chk("r_wb_phase",    32'(phase),   32'd3);
      do_br   = 1'($urandom_range(0, 1));
      tgt     = 8'($urandom);
      do_halt = ($urandom_range(0, 7) == 0);
      start = 1'($urandom_range(0, 1));
      halt_req = do_halt; branch_en = do_br; branch_addr = tgt;
      tick();
      pc_m  = do_br ? tgt : 8'(pc_m + 8'd1);
      ret_m = (ret_m == 16'hFFFF) ? ret_m : ret_m + 16'd1;
      if (do_halt) begin
        chk("r_halt_flag", 32'(halted),  32'd1);
        chk("r_halt_run",  32'(running), 32'd0);
        chk("r_halt_en",   32'(en_IR),   32'd0);
        chk("r_halt_pc",   32'(pc),      32'(pc_m));
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
          noise(1'b0); tick();
          chk("r_halt_hold", 32'(halted), 32'd1);
          chk("r_halt_pc2",  32'(pc),     32'(pc_m));
        end
        noise(1'b0); start = 1'b1;
        tick();
        chk("r_restart_run", 32'(running), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
